// File: rtl/pll_lock_supervisor_if.sv
// PLL-side signal bundle for the lock supervisor; lock_loss_count exists only with PLL_SUPERVISOR_STATS_EN.
// Latency: none (wires only); no backpressure, all signals are level-valued.
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       pll_reset;
    logic       sys_reset;
    logic       fault;
    logic [7:0] retry_count;
`ifdef PLL_SUPERVISOR_STATS_EN
    logic [15:0] lock_loss_count;

    modport master (output pll_locked, input pll_reset, sys_reset, fault, retry_count, lock_loss_count);
    modport slave  (input pll_locked, output pll_reset, sys_reset, fault, retry_count, lock_loss_count);
`else
    modport master (output pll_locked, input pll_reset, sys_reset, fault, retry_count);
    modport slave  (input pll_locked, output pll_reset, sys_reset, fault, retry_count);
`endif
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL power-up sequencer and lock supervisor; PLL_SUPERVISOR_STATS_EN adds a lock-loss counter.
// Latency: lock input seen 2 cycles after sampling, outputs registered; no backpressure.
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_lock_supervisor_if.slave bus
);
    localparam int RW = $clog2(RESET_CYCLES) + 1;
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, RUN, FAULT} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, lk_q, lk_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] stb_q, stb_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    retry_q, retry_d, retry_inc;
    logic          pll_reset_q, pll_reset_d;
    logic          sys_reset_q, sys_reset_d;
    logic          fault_q, fault_d;
    logic          fail;
`ifdef PLL_SUPERVISOR_STATS_EN
    logic [15:0]   lls_q, lls_d;
`endif

    always_comb begin
        sync1_d   = bus.pll_locked;
        lk_d      = sync1_q;
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_d     = stb_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    rst_cnt_d = '0;
                    tmo_d     = '0;
                    stb_d     = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            WAIT_LOCK: begin
                tmo_d = tmo_q + TW'(1);
                stb_d = lk_q ? stb_q + SW'(1) : '0;
                // A lock that completes on the timeout cycle still wins.
                if (lk_q && stb_q == SW'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end
            end
            RUN: begin
                if (!lk_q) begin
                    fail = 1'b1;
                end
            end
            default: ;
        endcase

        if (fail) begin
            retry_d   = retry_inc;
            rst_cnt_d = '0;
            state_d   = (retry_inc > 8'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end

        pll_reset_d = !(state_d == WAIT_LOCK || state_d == RUN);
        sys_reset_d = (state_d != RUN);
        fault_d     = (state_d == FAULT);

`ifdef PLL_SUPERVISOR_STATS_EN
        lls_d = lls_q;
        if (state_q == RUN && fail && lls_q != 16'hFFFF) begin
            lls_d = lls_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLL_RST;
            sync1_q     <= 1'b0;
            lk_q        <= 1'b0;
            rst_cnt_q   <= '0;
            stb_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            fault_q     <= 1'b0;
`ifdef PLL_SUPERVISOR_STATS_EN
            lls_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            lk_q        <= lk_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_q       <= stb_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            fault_q     <= fault_d;
`ifdef PLL_SUPERVISOR_STATS_EN
            lls_q       <= lls_d;
`endif
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.fault       = fault_q;
    assign bus.retry_count = retry_q;
`ifdef PLL_SUPERVISOR_STATS_EN
    assign bus.lock_loss_count = lls_q;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RESET_CYCLES=4 STABLE_CYCLES=8 LOCK_TIMEOUT=32 MAX_RETRIES=3.
// Edge e counts rising edges since reset release; outputs are sampled 1 time unit after each edge.
module tb_pll_lock_supervisor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .RESET_CYCLES (4),
        .STABLE_CYCLES(8),
        .LOCK_TIMEOUT (32),
        .MAX_RETRIES  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vecs++; if (bus.pll_reset !== 1'b1) begin errs++; $display("FAIL rst_pll got=%b want=1", bus.pll_reset); end
        vecs++; if (bus.sys_reset !== 1'b1) begin errs++; $display("FAIL rst_sys got=%b want=1", bus.sys_reset); end
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL rst_fault got=%b want=0", bus.fault); end
        vecs++; if (bus.retry_count !== 8'd0) begin errs++; $display("FAIL rst_retry got=%0d want=0", bus.retry_count); end
    endtask

    // Raw lock sampled from edge 6 -> synchronised by 8 -> 8 stable counts -> release at edge 15.
    task automatic test_clean_lock;
        logic exp_pll, exp_sys;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 5) bus.pll_locked = 1'b1;
            exp_pll = (e < 4);
            exp_sys = (e < 15);
            vecs++; if (bus.pll_reset !== exp_pll) begin errs++; $display("FAIL clean_pll e=%0d got=%b want=%b", e, bus.pll_reset, exp_pll); end
            vecs++; if (bus.sys_reset !== exp_sys) begin errs++; $display("FAIL clean_sys e=%0d got=%b want=%b", e, bus.sys_reset, exp_sys); end
        end
        vecs++; if (bus.retry_count !== 8'd0) begin errs++; $display("FAIL clean_retry got=%0d want=0", bus.retry_count); end
    endtask

    // Single low sample at edge 11 restarts the stable count: release moves from 15 to 21.
    task automatic test_glitch;
        logic exp_sys;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e == 5)  bus.pll_locked = 1'b1;
            if (e == 10) bus.pll_locked = 1'b0;
            if (e == 11) bus.pll_locked = 1'b1;
            exp_sys = (e < 21);
            vecs++; if (bus.sys_reset !== exp_sys) begin errs++; $display("FAIL glitch_sys e=%0d got=%b want=%b", e, bus.sys_reset, exp_sys); end
        end
    endtask

    // Attempts fail every 36 edges; the 4th failure (edge 144) parks in FAULT.
    task automatic test_timeout;
        logic       exp_pll, exp_fault;
        logic [7:0] exp_retry;
        do_reset();
        for (int e = 1; e <= 200; e++) begin
            tick();
            exp_fault = (e >= 144);
            exp_pll   = exp_fault ? 1'b1 : ((e % 36) < 4);
            exp_retry = (e >= 144) ? 8'd4 : 8'(e / 36);
            vecs++; if (bus.pll_reset !== exp_pll) begin errs++; $display("FAIL tmo_pll e=%0d got=%b want=%b", e, bus.pll_reset, exp_pll); end
            vecs++; if (bus.sys_reset !== 1'b1) begin errs++; $display("FAIL tmo_sys e=%0d got=%b want=1", e, bus.sys_reset); end
            vecs++; if (bus.fault !== exp_fault) begin errs++; $display("FAIL tmo_fault e=%0d got=%b want=%b", e, bus.fault, exp_fault); end
            vecs++; if (bus.retry_count !== exp_retry) begin errs++; $display("FAIL tmo_retry e=%0d got=%0d want=%0d", e, bus.retry_count, exp_retry); end
        end
    endtask

    // Lock dropped for the sample at edge 21: fail at 23, PLL reset 23..26, re-release at 35.
    task automatic test_run_loss;
        logic       exp_pll, exp_sys;
        logic [7:0] exp_retry;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 5)  bus.pll_locked = 1'b1;
            if (e == 20) bus.pll_locked = 1'b0;
            if (e == 21) bus.pll_locked = 1'b1;
            exp_pll   = (e < 4) || (e >= 23 && e < 27);
            exp_sys   = (e < 15) || (e >= 23 && e < 35);
            exp_retry = (e >= 23) ? 8'd1 : 8'd0;
            vecs++; if (bus.pll_reset !== exp_pll) begin errs++; $display("FAIL loss_pll e=%0d got=%b want=%b", e, bus.pll_reset, exp_pll); end
            vecs++; if (bus.sys_reset !== exp_sys) begin errs++; $display("FAIL loss_sys e=%0d got=%b want=%b", e, bus.sys_reset, exp_sys); end
            vecs++; if (bus.retry_count !== exp_retry) begin errs++; $display("FAIL loss_retry e=%0d got=%0d want=%0d", e, bus.retry_count, exp_retry); end
        end
    endtask

    task automatic test_reset_mid;
        logic exp_sys;
        do_reset();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        vecs++; if (bus.pll_reset !== 1'b1) begin errs++; $display("FAIL midrst_pll got=%b want=1", bus.pll_reset); end
        vecs++; if (bus.sys_reset !== 1'b1) begin errs++; $display("FAIL midrst_sys got=%b want=1", bus.sys_reset); end
        reset = 1'b0;
        repeat (3) tick();
        vecs++; if (bus.pll_reset !== 1'b1) begin errs++; $display("FAIL midrst_pll3 got=%b want=1", bus.pll_reset); end
        tick();
        vecs++; if (bus.pll_reset !== 1'b0) begin errs++; $display("FAIL midrst_pll4 got=%b want=0", bus.pll_reset); end
        repeat (150) tick();
        vecs++; if (bus.fault !== 1'b1) begin errs++; $display("FAIL fault_reached got=%b want=1", bus.fault); end
        vecs++; if (bus.retry_count !== 8'd4) begin errs++; $display("FAIL fault_retry got=%0d want=4", bus.retry_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++; if (bus.fault !== 1'b0) begin errs++; $display("FAIL faultrst_fault got=%b want=0", bus.fault); end
        vecs++; if (bus.retry_count !== 8'd0) begin errs++; $display("FAIL faultrst_retry got=%0d want=0", bus.retry_count); end
        vecs++; if (bus.pll_reset !== 1'b1) begin errs++; $display("FAIL faultrst_pll got=%b want=1", bus.pll_reset); end
        vecs++; if (bus.sys_reset !== 1'b1) begin errs++; $display("FAIL faultrst_sys got=%b want=1", bus.sys_reset); end
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 5) bus.pll_locked = 1'b1;
            exp_sys = (e < 15);
            vecs++; if (bus.sys_reset !== exp_sys) begin errs++; $display("FAIL resume_sys e=%0d got=%b want=%b", e, bus.sys_reset, exp_sys); end
        end
    endtask

`ifdef PLL_SUPERVISOR_STATS_EN
    task automatic test_stats;
        do_reset();
        bus.pll_locked = 1'b1;
        repeat (20) tick();
        vecs++; if (bus.lock_loss_count !== 16'd0) begin errs++; $display("FAIL stats_init got=%0d want=0", bus.lock_loss_count); end
        for (int k = 1; k <= 3; k++) begin
            bus.pll_locked = 1'b0;
            tick();
            bus.pll_locked = 1'b1;
            repeat (16) tick();
            vecs++; if (bus.lock_loss_count !== 16'(k)) begin errs++; $display("FAIL stats_loss k=%0d got=%0d want=%0d", k, bus.lock_loss_count, k); end
            vecs++; if (bus.sys_reset !== 1'b0) begin errs++; $display("FAIL stats_rerelease k=%0d got=%b want=0", k, bus.sys_reset); end
        end
        do_reset();
        repeat (80) tick();
        vecs++; if (bus.retry_count !== 8'd2) begin errs++; $display("FAIL stats_tmo_retry got=%0d want=2", bus.retry_count); end
        vecs++; if (bus.lock_loss_count !== 16'd0) begin errs++; $display("FAIL stats_tmo got=%0d want=0", bus.lock_loss_count); end
    endtask
`endif

    initial begin
        bus.pll_locked = 1'b0;
        test_reset();
        test_clean_lock();
        test_glitch();
        test_timeout();
        test_run_loss();
        test_reset_mid();
`ifdef PLL_SUPERVISOR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
